alarm_bank: RTL and testbench
=============================

ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm slots (1..16).
REQ-002 Parameter SNOOZE_MIN, default 5, minutes added on snooze (1..59).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 INCREMENT  input  1  level; each rising edge (detected on CLK) steps the selected field up by 1.
REQ-006 DECREMENT  input  1  level; each rising edge steps the selected field down by 1.
REQ-007 ORDER  input  2  field select: 00 seconds, 01 minutes, 10 hours, 11 none.
REQ-008 SEL  input  $clog2(NUM_ALARMS) (min 1)  alarm slot being viewed/edited.
REQ-009 ARM  input  1  one-cycle pulse; toggles ENABLED[SEL].
REQ-010 DISMISS  input  1  one-cycle pulse; clears all RINGING bits.
REQ-011 CUR_SEC / CUR_MIN / CUR_HR  input  8 each  current time of day, binary.
REQ-012 seconds / minutes / hours  output  8 each  stored fields of slot SEL, combinational mux of registers.
REQ-013 ENABLED  output  NUM_ALARMS  per-slot arm state.
REQ-014 RINGING  output  NUM_ALARMS  per-slot latched alarm flag.
REQ-015 RING  output  1  OR of RINGING.

Function
REQ-016 Edge detect: previous INCREMENT/DECREMENT registered each cycle; step occurs in the cycle where input=1 and previous=0; result visible after that CLK edge.
REQ-017 Only slot SEL, field ORDER is modified; ORDER=11 or SEL>=NUM_ALARMS -> no change.
REQ-018 Increment and decrement edges in the same cycle -> no change.
REQ-019 Seconds/minutes range 0..59: 59+1 -> 0, 0-1 -> 59; hours range 0..23: 23+1 -> 0, 0-1 -> 23; no carry between fields on edit.
REQ-020 Match[i] = ENABLED[i] and all three fields equal CUR_*; RINGING[i] set on the cycle after Match[i] rises (previous-match register per slot), so a held match fires once.
REQ-021 DISMISS clears all RINGING; a new match rising in the same cycle as DISMISS sets its bit (set wins).
REQ-022 ARM toggles ENABLED[SEL]; disabling a slot clears its RINGING and previous-match bits in the same edge.
REQ-023 Editing a ringing slot leaves RINGING unchanged; the edited value is compared from the next cycle.

Reset
REQ-024 While RESET=1: all fields 0, ENABLED=0, RINGING=0, previous-match=0, RING=0.
REQ-025 During reset edge-detect registers load the live inputs, so an input held high across reset release produces no step.
REQ-026 Reset mid-edit or mid-ring discards the pending operation; no output changes the cycle after release unless a new event occurs.

Configuration
REQ-027 Macro ALARM_SNOOZE_EN defined: input SNOOZE (1, pulse) exists; on SNOOZE every ringing slot clears RINGING and adds SNOOZE_MIN to minutes mod 60 with carry into hours mod 24, seconds unchanged; snooze overrides a same-cycle edit of that slot; DISMISS in same cycle takes priority over SNOOZE (no time change).
REQ-028 Macro undefined: SNOOZE port and snooze logic absent; all other behaviour identical.

Structure
REQ-029 Package alarm_pkg holds field-select enum (SEC, MIN, HR, NONE), SEC_MAX=59, MIN_MAX=59, HR_MAX=23, and a time-triple struct of three 8-bit fields.
REQ-030 Sub-module alarm_slot: one slot's three field registers, wrap arithmetic, enable, previous-match and ringing flag; alarm_bank instantiates NUM_ALARMS copies via generate and owns edge detect and output mux.

Verification
REQ-031 Reset, SEL=0, ORDER=00, 60 INCREMENT edges -> seconds 1..59 then 0; one DECREMENT edge -> 59.
REQ-032 Slot 2 hours=23, INCREMENT edge ORDER=10 -> hours 0; minutes and slots 0,1,3 unchanged; INCREMENT+DECREMENT same cycle -> no change.
REQ-033 Slot 1 set 06:30:00, ARM, drive CUR 06:30:00 for 5 cycles -> RINGING=0010 one cycle later, RING=1, stays set; DISMISS -> RINGING=0, no refire while CUR held.
REQ-034 Slot 1 ringing, ARM on SEL=1 -> ENABLED[1]=0, RINGING[1]=0 next cycle; CUR match afterwards -> no ring.
REQ-035 With ALARM_SNOOZE_EN, slot 0 at 23:58:10 ringing, SNOOZE (SNOOZE_MIN=5) -> 00:03:10, RINGING=0; CUR 00:03:10 -> rings again.
REQ-036 INCREMENT held high across RESET release -> seconds stay 0; next fresh edge -> 1.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm bank.
// Time triple, field select and wrap arithmetic.
package alarm_pkg;

  typedef enum logic [1:0] {
    SEC  = 2'b00,
    MIN  = 2'b01,
    HR   = 2'b10,
    NONE = 2'b11
  } field_e;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;
  localparam logic [7:0] HR_MAX  = 8'd23;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] min;
    logic [7:0] sec;
  } time_t;

  function automatic logic [7:0] step(
    input logic [7:0] v,
    input logic [7:0] max,
    input logic       up
  );
    if (up) return (v >= max) ? 8'd0 : v + 8'd1;
    return (v == 8'd0) ? max : v - 8'd1;
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: time fields, arm state and latched ring flag.
// Snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_slot
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 5
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   hit,
  input  logic   up,
  input  logic   dn,
  input  logic   arm,
  input  logic   dismiss,
`ifdef ALARM_SNOOZE_EN
  input  logic   snooze,
`endif
  input  field_e field,
  input  time_t  cur,
  output time_t  tm,
  output logic   enabled,
  output logic   ringing
);

  logic  match;
  logic  prev_match;
  time_t tm_n;
  logic  en_n;
  logic  ring_n;
  logic  pm_n;

  assign match = enabled && (tm == cur);

`ifdef ALARM_SNOOZE_EN
  logic [7:0] snz_min;
  assign snz_min = tm.min + 8'(SNOOZE_MIN);
`endif

  always_comb begin
    tm_n   = tm;
    en_n   = enabled;
    pm_n   = match;
    ring_n = ringing;
    if (dismiss) ring_n = 1'b0;
    // a fresh match beats a same-cycle dismiss
    if (match && !prev_match) ring_n = 1'b1;
    if (hit && (up || dn)) begin
      unique case (field)
        SEC:  tm_n.sec = step(tm.sec, SEC_MAX, up);
        MIN:  tm_n.min = step(tm.min, MIN_MAX, up);
        HR:   tm_n.hr  = step(tm.hr, HR_MAX, up);
        NONE: ;
      endcase
    end
`ifdef ALARM_SNOOZE_EN
    if (snooze && ringing && !dismiss) begin
      ring_n     = 1'b0;
      tm_n.sec   = tm.sec;
      if (snz_min > MIN_MAX) begin
        tm_n.min = snz_min - 8'd60;
        tm_n.hr  = step(tm.hr, HR_MAX, 1'b1);
      end else begin
        tm_n.min = snz_min;
        tm_n.hr  = tm.hr;
      end
    end
`endif
    if (hit && arm) begin
      en_n = !enabled;
      if (enabled) begin
        ring_n = 1'b0;
        pm_n   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tm         <= '0;
      enabled    <= 1'b0;
      ringing    <= 1'b0;
      prev_match <= 1'b0;
    end else begin
      tm         <= tm_n;
      enabled    <= en_n;
      ringing    <= ring_n;
      prev_match <= pm_n;
    end
  end

endmodule

// File: rtl/alarm_bank.sv
// Bank of NUM_ALARMS alarm slots with edge-detected editing.
// Optional snooze input when ALARM_SNOOZE_EN is defined.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  localparam int SW = $clog2(NUM_ALARMS > 1 ? NUM_ALARMS : 2)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  INCREMENT,
  input  logic                  DECREMENT,
  input  logic [1:0]            ORDER,
  input  logic [SW-1:0]         SEL,
  input  logic                  ARM,
  input  logic                  DISMISS,
`ifdef ALARM_SNOOZE_EN
  input  logic                  SNOOZE,
`endif
  input  logic [7:0]            CUR_SEC,
  input  logic [7:0]            CUR_MIN,
  input  logic [7:0]            CUR_HR,
  output logic [7:0]            seconds,
  output logic [7:0]            minutes,
  output logic [7:0]            hours,
  output logic [NUM_ALARMS-1:0] ENABLED,
  output logic [NUM_ALARMS-1:0] RINGING,
  output logic                  RING
);

  logic  prev_inc;
  logic  prev_dec;
  logic  inc_edge;
  logic  dec_edge;
  logic  up;
  logic  dn;
  time_t cur;
  time_t view;
  time_t slot_tm [NUM_ALARMS];

  // loads during reset too, so a level held across release is not an edge
  always_ff @(posedge CLK) begin
    prev_inc <= INCREMENT;
    prev_dec <= DECREMENT;
  end

  assign inc_edge = INCREMENT && !prev_inc;
  assign dec_edge = DECREMENT && !prev_dec;
  assign up       = inc_edge && !dec_edge;
  assign dn       = dec_edge && !inc_edge;
  assign cur      = '{hr: CUR_HR, min: CUR_MIN, sec: CUR_SEC};

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    alarm_slot #(
      .SNOOZE_MIN(SNOOZE_MIN)
    ) u_slot (
      .clk     (CLK),
      .rst     (RESET),
      .hit     (int'(SEL) == i),
      .up      (up),
      .dn      (dn),
      .arm     (ARM),
      .dismiss (DISMISS),
`ifdef ALARM_SNOOZE_EN
      .snooze  (SNOOZE),
`endif
      .field   (field_e'(ORDER)),
      .cur     (cur),
      .tm      (slot_tm[i]),
      .enabled (ENABLED[i]),
      .ringing (RINGING[i])
    );
  end

  always_comb begin
    view = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (int'(SEL) == i) view = slot_tm[i];
  end

  assign seconds = view.sec;
  assign minutes = view.min;
  assign hours   = view.hr;
  assign RING    = |RINGING;

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed scenarios then
// randomized traffic against a time-of-day reference model.
module tb_alarm_bank;
  localparam int N   = 4;
  localparam int SNZ = 5;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         INCREMENT;
  logic         DECREMENT;
  logic [1:0]   ORDER;
  logic [1:0]   SEL;
  logic         ARM;
  logic         DISMISS;
`ifdef ALARM_SNOOZE_EN
  logic         SNOOZE;
`endif
  logic [7:0]   CUR_SEC;
  logic [7:0]   CUR_MIN;
  logic [7:0]   CUR_HR;
  logic [7:0]   seconds;
  logic [7:0]   minutes;
  logic [7:0]   hours;
  logic [N-1:0] ENABLED;
  logic [N-1:0] RINGING;
  logic         RING;

  alarm_bank #(
    .NUM_ALARMS(N),
    .SNOOZE_MIN(SNZ)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .INCREMENT (INCREMENT),
    .DECREMENT (DECREMENT),
    .ORDER     (ORDER),
    .SEL       (SEL),
    .ARM       (ARM),
    .DISMISS   (DISMISS),
`ifdef ALARM_SNOOZE_EN
    .SNOOZE    (SNOOZE),
`endif
    .CUR_SEC   (CUR_SEC),
    .CUR_MIN   (CUR_MIN),
    .CUR_HR    (CUR_HR),
    .seconds   (seconds),
    .minutes   (minutes),
    .hours     (hours),
    .ENABLED   (ENABLED),
    .RINGING   (RINGING),
    .RING      (RING)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: times as plain integers
  int m_sec [N];
  int m_min [N];
  int m_hr  [N];
  bit m_en  [N];
  bit m_pm  [N];
  bit m_ring[N];
  bit m_pi;
  bit m_pd;

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ie, de, snz, was;
    bit mt[N];
    int osec, omin, ohr, t;
    ie = INCREMENT && !m_pi;
    de = DECREMENT && !m_pd;
    m_pi = INCREMENT;
    m_pd = DECREMENT;
    snz = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz = SNOOZE;
`endif
    if (RESET) begin
      for (int i = 0; i < N; i++) begin
        m_sec[i] = 0; m_min[i] = 0; m_hr[i] = 0;
        m_en[i] = 0; m_pm[i] = 0; m_ring[i] = 0;
      end
      return;
    end
    for (int i = 0; i < N; i++)
      mt[i] = m_en[i] && m_sec[i] == int'(CUR_SEC)
           && m_min[i] == int'(CUR_MIN) && m_hr[i] == int'(CUR_HR);
    for (int i = 0; i < N; i++) begin
      osec = m_sec[i]; omin = m_min[i]; ohr = m_hr[i];
      was  = m_ring[i];
      if (DISMISS) m_ring[i] = 0;
      if (mt[i] && !m_pm[i]) m_ring[i] = 1;
      m_pm[i] = mt[i];
      if (int'(SEL) == i && ie != de) begin
        case (ORDER)
          2'd0: m_sec[i] = (osec + (ie ? 1 : 59)) % 60;
          2'd1: m_min[i] = (omin + (ie ? 1 : 59)) % 60;
          2'd2: m_hr[i]  = (ohr + (ie ? 1 : 23)) % 24;
          default: ;
        endcase
      end
      if (snz && was && !DISMISS) begin
        t = (ohr * 60 + omin + SNZ) % 1440;
        m_hr[i] = t / 60; m_min[i] = t % 60; m_sec[i] = osec;
        m_ring[i] = 0;
      end
      if (int'(SEL) == i && ARM) begin
        if (m_en[i]) begin m_ring[i] = 0; m_pm[i] = 0; end
        m_en[i] = !m_en[i];
      end
    end
  endtask

  task automatic compare_all();
    int s, e, r;
    s = int'(SEL);
    e = 0; r = 0;
    for (int i = 0; i < N; i++) begin
      e |= int'(m_en[i]) << i;
      r |= int'(m_ring[i]) << i;
    end
    chk("sec", int'(seconds), m_sec[s]);
    chk("min", int'(minutes), m_min[s]);
    chk("hr", int'(hours), m_hr[s]);
    chk("enabled", int'(ENABLED), e);
    chk("ringing", int'(RINGING), r);
    chk("ring", int'(RING), int'(r != 0));
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic idle();
    RESET = 0; INCREMENT = 0; DECREMENT = 0; ARM = 0; DISMISS = 0;
`ifdef ALARM_SNOOZE_EN
    SNOOZE = 0;
`endif
  endtask

  task automatic do_reset();
    idle();
    RESET = 1; cycle(); cycle(); RESET = 0;
  endtask

  task automatic bump(int s, int ord, bit upd, int n);
    SEL = 2'(s); ORDER = 2'(ord);
    repeat (n) begin
      if (upd) INCREMENT = 1; else DECREMENT = 1;
      cycle();
      INCREMENT = 0; DECREMENT = 0;
      cycle();
    end
  endtask

  task automatic set_cur(int h, int m, int s);
    CUR_HR = 8'(h); CUR_MIN = 8'(m); CUR_SEC = 8'(s);
  endtask

  task automatic pulse_arm(int s);
    SEL = 2'(s); ARM = 1; cycle(); ARM = 0;
  endtask

  initial begin
    int j;
    idle();
    SEL = 0; ORDER = 0;
    set_cur(99, 99, 99);
    do_reset();
    chk("rst_ring", int'(RING), 0);
    chk("rst_enabled", int'(ENABLED), 0);
    chk("rst_sec", int'(seconds), 0);

    // seconds wrap upward and back
    SEL = 0; ORDER = 0;
    for (int k = 1; k <= 60; k++) begin
      INCREMENT = 1; cycle();
      chk("sec_inc", int'(seconds), k % 60);
      INCREMENT = 0; cycle();
    end
    bump(0, 0, 0, 1);
    chk("sec_dec_wrap", int'(seconds), 59);

    // hours wrap and simultaneous edges
    bump(2, 2, 0, 1);
    chk("hr_dec_wrap", int'(hours), 23);
    bump(2, 2, 1, 1);
    chk("hr_inc_wrap", int'(hours), 0);
    INCREMENT = 1; DECREMENT = 1; cycle();
    INCREMENT = 0; DECREMENT = 0; cycle();
    chk("both_edges", int'(hours), 0);
    ORDER = 3; bump(2, 3, 1, 2);
    chk("order_none", int'(seconds), 0);

    // slot 1 at 06:30:00 rings once
    do_reset();
    bump(1, 2, 1, 6);
    bump(1, 1, 1, 30);
    pulse_arm(1);
    set_cur(6, 30, 0);
    repeat (5) cycle();
    chk("ring_slot1", int'(RINGING), 2);
    chk("ring_or", int'(RING), 1);
    DISMISS = 1; cycle(); DISMISS = 0;
    repeat (3) cycle();
    chk("dismiss_hold", int'(RINGING), 0);

    // disarming a ringing slot
    set_cur(0, 0, 0); cycle();
    set_cur(6, 30, 0); cycle(); cycle();
    chk("rering", int'(RINGING), 2);
    pulse_arm(1);
    chk("disarm_en", int'(ENABLED), 0);
    chk("disarm_ring", int'(RINGING), 0);
    set_cur(0, 0, 0); cycle();
    set_cur(6, 30, 0); cycle(); cycle();
    chk("no_ring_off", int'(RING), 0);

`ifdef ALARM_SNOOZE_EN
    do_reset();
    bump(0, 2, 0, 1);
    bump(0, 1, 0, 2);
    bump(0, 0, 1, 10);
    pulse_arm(0);
    set_cur(23, 58, 10); cycle(); cycle();
    chk("snz_pre", int'(RINGING), 1);
    SNOOZE = 1; cycle(); SNOOZE = 0;
    chk("snz_hr", int'(hours), 0);
    chk("snz_min", int'(minutes), 3);
    chk("snz_sec", int'(seconds), 10);
    chk("snz_ring", int'(RINGING), 0);
    set_cur(0, 3, 10); cycle(); cycle();
    chk("snz_rering", int'(RINGING), 1);
`endif

    // increment held across reset release
    idle();
    SEL = 0; ORDER = 0;
    INCREMENT = 1; RESET = 1; cycle(); cycle();
    RESET = 0; cycle(); cycle();
    chk("held_inc", int'(seconds), 0);
    INCREMENT = 0; cycle();
    INCREMENT = 1; cycle();
    chk("fresh_inc", int'(seconds), 1);
    INCREMENT = 0; cycle();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      RESET     = ($urandom % 300) == 0;
      INCREMENT = 1'($urandom);
      DECREMENT = ($urandom % 3) == 0;
      ORDER     = 2'($urandom);
      SEL       = 2'($urandom);
      ARM       = ($urandom % 10) == 0;
      DISMISS   = ($urandom % 15) == 0;
`ifdef ALARM_SNOOZE_EN
      SNOOZE    = ($urandom % 9) == 0;
`endif
      if ($urandom % 3 == 0) begin
        j = int'($urandom % N);
        set_cur(m_hr[j], m_min[j], m_sec[j]);
      end else if ($urandom % 4 == 0) begin
        set_cur(int'($urandom % 3), int'($urandom % 3), int'($urandom % 3));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
